// File: rtl/uart_rx.sv
// Serial receiver with a 5..8 bit frame, optional parity, and stop-bit checking. One bit is sampled per tx_clk.
// Registered outputs; rx_done pulses for one cycle after the stop-bit edge. There is no backpressure.
module uart_rx (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [3:0] length,
  input  logic       parity_en,
  input  logic       parity_type,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_err,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t     state, state_nx;
  logic [2:0] count, count_nx;
  logic [7:0] shift, shift_nx;
  logic [3:0] len, len_nx;
  logic       pen, pen_nx, ptype, ptype_nx, pbad, pbad_nx;
  logic [7:0] rx_data_nx;
  logic       rx_done_nx, rx_err_nx, parity_err_nx, frame_err_nx;

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 3'd0;
      shift      <= 8'd0;
      len        <= 4'd8;
      pen        <= 1'b0;
      ptype      <= 1'b0;
      pbad       <= 1'b0;
      rx_data    <= 8'd0;
      rx_done    <= 1'b0;
      rx_err     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      shift      <= shift_nx;
      len        <= len_nx;
      pen        <= pen_nx;
      ptype      <= ptype_nx;
      pbad       <= pbad_nx;
      rx_data    <= rx_data_nx;
      rx_done    <= rx_done_nx;
      rx_err     <= rx_err_nx;
      parity_err <= parity_err_nx;
      frame_err  <= frame_err_nx;
      rx_busy    <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx      = state;
    count_nx      = count;
    shift_nx      = shift;
    len_nx        = len;
    pen_nx        = pen;
    ptype_nx      = ptype;
    pbad_nx       = pbad;
    rx_data_nx    = rx_data;
    rx_done_nx    = 1'b0;
    rx_err_nx     = 1'b0;
    parity_err_nx = parity_err;
    frame_err_nx  = frame_err;
    case (state)
      IDLE: begin
        if (!rx) begin
          state_nx = DATA;
          count_nx = 3'd0;
          shift_nx = 8'd0;
          if (length < 4'd5)      len_nx = 4'd5;
          else if (length > 4'd8) len_nx = 4'd8;
          else                    len_nx = length;
          pen_nx   = parity_en;
          ptype_nx = parity_type;
          pbad_nx  = 1'b0;
        end
      end
      DATA: begin
        shift_nx[count] = rx;
        if ({1'b0, count} == len - 4'd1) state_nx = pen ? PARITY : STOP;
        else                             count_nx = count + 3'd1;
      end
      PARITY: begin
        // Bits above len are still zero from the start bit, so they do not disturb the reduction.
        pbad_nx  = (rx != (ptype ? ^shift : ~^shift));
        state_nx = STOP;
      end
      STOP: begin
        rx_data_nx    = shift;
        parity_err_nx = pen & pbad;
        frame_err_nx  = ~rx;
        rx_done_nx    = 1'b1;
        rx_err_nx     = (pen & pbad) | ~rx;
        state_nx      = rx ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx. Each scenario task drives the line and checks its own expectations.
module tb_uart_rx;
  logic       tx_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [3:0] length = 4'd8;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done, rx_err, parity_err, frame_err, rx_busy;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] data_q[$];
  logic       err_q[$];

  uart_rx dut (
    .tx_clk(tx_clk), .rst(rst), .rx(rx), .length(length), .parity_en(parity_en),
    .parity_type(parity_type), .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
    .parity_err(parity_err), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 tx_clk = ~tx_clk;

  always @(posedge tx_clk) begin
    if (rx_done) begin
      data_q.push_back(rx_data);
      err_q.push_back(rx_err);
    end
  end

  function automatic logic [31:0] frame(input logic [7:0] d, input int n, input bit pen,
                                        input bit pbit, input bit stop);
    logic [31:0] f;
    f = 32'hFFFF_FFFF;
    f[0] = 1'b0;
    for (int i = 0; i < n; i++) f[1+i] = d[i];
    if (pen) f[n+1] = pbit;
    f[n+1+int'(pen)] = stop;
    return f;
  endfunction

  // Drives bits LSB first, one per rising edge; reports the first bit index after which rx_done was seen.
  task automatic send_bits(input logic [31:0] bits, input int n, output int done_edge);
    done_edge = -1;
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      @(posedge tx_clk); #1;
      if (rx_done && done_edge < 0) done_edge = i;
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin @(posedge tx_clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b0;
    repeat (2) @(posedge tx_clk);
    #1;
    n_chk++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    n_chk++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done got %b want 0", rx_done); end
    n_chk++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_rx_err got %b want 0", rx_err); end
    n_chk++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy got %b want 0", rx_busy); end
    rst = 1'b0; rx = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    int de;
    data_q.delete(); err_q.delete();
    length = 4'd8; parity_en = 1'b0;
    send_bits(frame(8'hA5, 8, 0, 0, 1), 10, de);
    n_chk++; if (de !== 9) begin n_fail++; $display("FAIL basic_latency got %0d want 9", de); end
    n_chk++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_rx_data got %h want a5", rx_data); end
    n_chk++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL basic_rx_err got %b want 0", rx_err); end
    idle(1);
    n_chk++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", rx_done); end
    n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_idle got %b want 0", rx_busy); end
    n_chk++; if (data_q.size() !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", data_q.size()); end
  endtask

  task automatic test_parity;
    int de;
    data_q.delete(); err_q.delete();
    length = 4'd5; parity_en = 1'b1; parity_type = 1'b1;
    send_bits(frame(8'h15, 5, 1, 1, 1), 8, de);
    n_chk++; if (de !== 7) begin n_fail++; $display("FAIL parity_latency got %0d want 7", de); end
    n_chk++; if (rx_data !== 8'h15) begin n_fail++; $display("FAIL parity_ok_data got %h want 15", rx_data); end
    n_chk++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_ok_err got %b want 0", parity_err); end
    idle(1);
    send_bits(frame(8'h15, 5, 1, 0, 1), 8, de);
    n_chk++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_bad_err got %b want 1", parity_err); end
    n_chk++; if (rx_err !== 1'b1) begin n_fail++; $display("FAIL parity_bad_rx_err got %b want 1", rx_err); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL parity_bad_frame_err got %b want 0", frame_err); end
    idle(3);
    n_chk++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_err_hold got %b want 1", parity_err); end
    n_chk++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL parity_rx_err_pulse got %b want 0", rx_err); end
    parity_type = 1'b0;
    send_bits(frame(8'h15, 5, 1, 0, 1), 8, de);
    n_chk++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_xnor_err got %b want 0", parity_err); end
    idle(1);
    parity_en = 1'b0;
  endtask

  task automatic test_frame_err;
    int de;
    data_q.delete(); err_q.delete();
    length = 4'd8; parity_en = 1'b0;
    send_bits(frame(8'h3C, 8, 0, 0, 0), 10, de);
    n_chk++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_flag got %b want 1", frame_err); end
    n_chk++; if (rx_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_rx_err got %b want 1", rx_err); end
    n_chk++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL frame_err_data got %h want 3c", rx_data); end
    send_bits(32'h0, 3, de);
    n_chk++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL frame_wait_busy got %b want 1", rx_busy); end
    idle(1);
    n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL frame_wait_release got %b want 0", rx_busy); end
    n_chk++; if (data_q.size() !== 1) begin n_fail++; $display("FAIL frame_wait_frames got %0d want 1", data_q.size()); end
    send_bits(frame(8'h81, 8, 0, 0, 1), 10, de);
    n_chk++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL frame_next_data got %h want 81", rx_data); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_next_err got %b want 0", frame_err); end
    idle(1);
  endtask

  task automatic test_reset_mid;
    int de;
    data_q.delete(); err_q.delete();
    length = 4'd8;
    send_bits(frame(8'hFF, 8, 0, 0, 1), 5, de);
    rst = 1'b1; rx = 1'b0;
    @(posedge tx_clk); #1;
    n_chk++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", rx_busy); end
    n_chk++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h want 00", rx_data); end
    rst = 1'b0;
    idle(12);
    n_chk++; if (data_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d want 0", data_q.size()); end
    send_bits(frame(8'h5A, 8, 0, 0, 1), 10, de);
    n_chk++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL rstmid_next_data got %h want 5a", rx_data); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    int de;
    logic [31:0] f;
    data_q.delete(); err_q.delete();
    length = 4'd8;
    f = frame(8'h12, 8, 0, 0, 1);
    f[19:10] = frame(8'hEF, 8, 0, 0, 1) & 32'h3FF;
    send_bits(f, 20, de);
    idle(1);
    n_chk++; if (data_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", data_q.size()); end
    if (data_q.size() == 2) begin
      n_chk++; if (data_q[0] !== 8'h12) begin n_fail++; $display("FAIL b2b_first got %h want 12", data_q[0]); end
      n_chk++; if (data_q[1] !== 8'hEF) begin n_fail++; $display("FAIL b2b_second got %h want ef", data_q[1]); end
    end
  endtask

  task automatic test_clamp;
    int de;
    length = 4'd12;
    send_bits(frame(8'hFF, 8, 0, 0, 1), 10, de);
    n_chk++; if (de !== 9) begin n_fail++; $display("FAIL clamp_hi_latency got %0d want 9", de); end
    n_chk++; if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL clamp_hi_data got %h want ff", rx_data); end
    idle(1);
    length = 4'd3;
    send_bits(frame(8'h1F, 5, 0, 0, 1), 7, de);
    n_chk++; if (de !== 6) begin n_fail++; $display("FAIL clamp_lo_latency got %0d want 6", de); end
    n_chk++; if (rx_data !== 8'h1F) begin n_fail++; $display("FAIL clamp_lo_data got %h want 1f", rx_data); end
    idle(1);
  endtask

  task automatic test_length_change;
    int de;
    logic [31:0] f;
    length = 4'd8; parity_en = 1'b0;
    f = frame(8'hC3, 8, 0, 0, 1);
    send_bits(f, 1, de);
    length = 4'd5; parity_en = 1'b1; parity_type = 1'b1;
    n_chk++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL chg_busy got %b want 1", rx_busy); end
    send_bits(f >> 1, 9, de);
    n_chk++; if (de !== 8) begin n_fail++; $display("FAIL chg_latency got %0d want 8", de); end
    n_chk++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL chg_data got %h want c3", rx_data); end
    n_chk++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL chg_parity_err got %b want 0", parity_err); end
    idle(1);
  endtask

  initial begin
    #1;
    test_reset;
    test_basic;
    test_parity;
    test_frame_err;
    test_reset_mid;
    test_back_to_back;
    test_clamp;
    test_length_change;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have no parameters; frame format is set by ports.
REQ-002 tx_clk  input  1  bit clock, one serial bit per rising edge; rx is sampled on every rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx  input  1  serial line, idle high, synchronous to tx_clk; no input synchronizer.
REQ-005 length  input  4  data bits per frame, valid 5..8.
REQ-006 parity_en  input  1  1 = frame carries a parity bit after the data.
REQ-007 parity_type  input  1  1 = expected parity is XOR of data bits; 0 = XNOR.
REQ-008 rx_data  output  8  last received word, LSB first on line, bits [7:length] zero.
REQ-009 rx_done  output  1  one-cycle pulse when a frame completes, good or bad.
REQ-010 rx_err  output  1  one-cycle pulse with rx_done when parity_err or frame_err is set.
REQ-011 parity_err  output  1  parity mismatch on last frame; valid and held from rx_done until the next rx_done.
REQ-012 frame_err  output  1  stop bit sampled 0 on last frame; valid and held from rx_done until the next rx_done.
REQ-013 rx_busy  output  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, DATA, PARITY, STOP, WAIT_HIGH; all outputs registered.
REQ-015 IDLE: rx sampled 0 -> DATA, count=0; latch length (clamped: <5 -> 5, >8 -> 8), parity_en and parity_type for the whole frame.
REQ-016 DATA: store sample into shift[count], count++; on the sample with count == len-1 -> PARITY if parity_en else STOP.
REQ-017 PARITY: one sample; parity_err_next = (sample != expected), expected computed over the len received bits per the latched parity_type.
REQ-018 STOP: one sample; frame_err_next = (sample == 0).
REQ-019 On the STOP sampling edge: rx_data <= shift zero-extended; parity_err, frame_err update; rx_done=1 and rx_err=(parity_err|frame_err) for exactly the following cycle.
REQ-020 After STOP: stop bit 1 -> IDLE; stop bit 0 -> WAIT_HIGH.
REQ-021 WAIT_HIGH: stay until rx sampled 1, then IDLE; a low line SHALL NOT be taken as a new start bit.
REQ-022 Latency: start sample at edge 0 -> rx_done high in the cycle after edge len+1 (no parity) or len+2 (parity).
REQ-023 Back-to-back: a start bit sampled in the cycle rx_done is high SHALL be accepted (IDLE entered on the STOP edge).
REQ-024 Input changes to length/parity_en/parity_type mid-frame SHALL have no effect on the current frame.
REQ-025 rx_data, parity_err and frame_err SHALL hold their values between rx_done pulses; parity_err=0 when parity_en=0.

Reset
REQ-026 rst sampled high: state IDLE, count 0, shift 0, rx_data 0x00, rx_done 0, rx_err 0, parity_err 0, frame_err 0, rx_busy 0.
REQ-027 rst mid-frame SHALL abort the frame with no rx_done; reception resumes at the first start bit sampled after rst deasserts.
REQ-028 rst has priority over all state transitions in the same cycle.

Verification
REQ-029 length=8, parity_en=0, line 0,1,0,1,0,0,1,0,1,1 (0xA5 LSB first, stop 1) -> rx_data=0xA5, rx_done 1 cycle, rx_err=0, latency 9 edges.
REQ-030 length=5, parity_en=1, parity_type=1, data 0x15 (bits 1,0,1,0,1), parity 1, stop 1 -> rx_data=0x15, parity_err=0; repeat with parity 0 -> parity_err=1, rx_err pulse.
REQ-031 length=8, data 0x3C, stop 0, rx held low 3 more cycles then high -> frame_err=1, rx_data=0x3C, no new frame until rx returns high, then 0x81 frame received cleanly.
REQ-032 rst pulsed after 4 data bits of a length 8 frame -> no rx_done, outputs 0; following 0x5A frame -> rx_data=0x5A.
REQ-033 two back-to-back frames, 0x12 then 0xEF, start bit sampled in the cycle rx_done is high -> two rx_done pulses, rx_data 0x12 then 0xEF.
REQ-034 length=12, data 0xFF -> treated as length 8, rx_data=0xFF; length=3 -> treated as 5 bits, bits [7:5]=0.
